// File: rtl/rv32i_mem_bridge.sv
// Arbitrates NUM_CH 32-bit requesters onto a 16-bit PSRAM controller as two halfword beats.
// Define MEM_BRIDGE_RR_EN for round-robin arbitration; otherwise lowest channel index wins.
module rv32i_mem_bridge #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 23
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*32-1:0]     req_wdata,
  input  logic [NUM_CH*4-1:0]      req_be,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic [21:0]              ctl_addr,
  output logic                     ctl_write_en,
  output logic                     ctl_read_en,
  output logic [15:0]              ctl_data_in,
  output logic                     ctl_write_high_byte,
  output logic                     ctl_write_low_byte,
  input  logic                     ctl_busy,
  input  logic                     ctl_read_avail,
  input  logic [15:0]              ctl_data_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE, ARB, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CH_W-1:0]   r_ch;
  logic              r_we;
  logic [ADDR_W-3:0] r_widx;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_rbuf;

  logic [CH_W-1:0]   w_gnt_ch;
  logic              w_gnt_vld;
  logic              w_sel_we;
  logic [ADDR_W-3:0] w_sel_widx;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_be;
  logic              w_unused_addr_lsb;
  logic              w_hi;
  logic [1:0]        w_beat_be;
  logic [15:0]       w_beat_dat;
  logic              w_skip;

`ifdef MEM_BRIDGE_RR_EN
  logic [CH_W-1:0] r_rr_ptr;

  // Lowest requesting channel at or above the pointer, else wrap to lowest overall.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (req_valid[c]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CH_W'(c);
      end
    end
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (req_valid[c] && (CH_W'(c) >= r_rr_ptr)) begin
        w_gnt_ch = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (r_state == ARB && w_gnt_vld) begin
      r_rr_ptr <= (w_gnt_ch == CH_W'(NUM_CH-1)) ? '0 : w_gnt_ch + CH_W'(1);
    end
  end
`else
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    for (int c = NUM_CH-1; c >= 0; c--) begin
      if (req_valid[c]) begin
        w_gnt_vld = 1'b1;
        w_gnt_ch  = CH_W'(c);
      end
    end
  end
`endif

  // Byte offset addr[1:0] never reaches the controller; only the word index is kept.
  always_comb begin
    w_sel_we          = 1'b0;
    w_sel_widx        = '0;
    w_sel_wdata       = '0;
    w_sel_be          = '0;
    w_unused_addr_lsb = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_unused_addr_lsb = w_unused_addr_lsb ^ (^req_addr[c*ADDR_W +: 2]);
      if (w_gnt_ch == CH_W'(c)) begin
        w_sel_we    = req_we[c];
        w_sel_widx  = req_addr[c*ADDR_W+2 +: ADDR_W-2];
        w_sel_wdata = req_wdata[c*32 +: 32];
        w_sel_be    = req_be[c*4 +: 4];
      end
    end
  end

  assign w_hi       = (r_state == ISSUE_HI) || (r_state == WAIT_HI);
  assign w_beat_be  = w_hi ? r_be[3:2] : r_be[1:0];
  assign w_beat_dat = w_hi ? r_wdata[31:16] : r_wdata[15:0];
  assign w_skip     = r_we && (w_beat_be == 2'b00);
  assign ctl_addr   = 22'({r_widx, w_hi});

  always_comb begin
    w_next              = r_state;
    req_ready           = '0;
    rsp_valid           = '0;
    rsp_rdata           = '0;
    ctl_write_en        = 1'b0;
    ctl_read_en         = 1'b0;
    ctl_data_in         = '0;
    ctl_write_high_byte = 1'b0;
    ctl_write_low_byte  = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid) w_next = ARB;
      end
      ARB: begin
        if (w_gnt_vld) begin
          req_ready[w_gnt_ch] = 1'b1;
          w_next              = ISSUE_LO;
        end else begin
          w_next = IDLE;
        end
      end
      ISSUE_LO, ISSUE_HI: begin
        if (r_we && r_be == 4'b0000) begin
          w_next = RESP;
        end else if (w_skip) begin
          w_next = w_hi ? RESP : ISSUE_HI;
        end else if (!ctl_busy) begin
          if (r_we) begin
            ctl_write_en        = 1'b1;
            ctl_data_in         = w_beat_dat;
            ctl_write_high_byte = w_beat_be[1];
            ctl_write_low_byte  = w_beat_be[0];
          end else begin
            ctl_read_en = 1'b1;
          end
          w_next = w_hi ? WAIT_HI : WAIT_LO;
        end
      end
      WAIT_LO, WAIT_HI: begin
        if (r_we ? !ctl_busy : ctl_read_avail) begin
          w_next = w_hi ? RESP : ISSUE_HI;
        end
      end
      RESP: begin
        rsp_valid[r_ch] = 1'b1;
        rsp_rdata       = r_we ? 32'h0 : r_rbuf;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rbuf  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ARB && w_gnt_vld) begin
        r_ch    <= w_gnt_ch;
        r_we    <= w_sel_we;
        r_widx  <= w_sel_widx;
        r_wdata <= w_sel_wdata;
        r_be    <= w_sel_be;
      end
      if (!r_we && ctl_read_avail) begin
        if (r_state == WAIT_LO) r_rbuf[15:0]  <= ctl_data_out;
        if (r_state == WAIT_HI) r_rbuf[31:16] <= ctl_data_out;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_mem_bridge.sv
// Directed bench for rv32i_mem_bridge with a behavioural PSRAM controller model.
module tb_rv32i_mem_bridge;
  localparam int NCH = 2;
  localparam int AW  = 23;

  logic              clk;
  logic              reset_n;
  logic [NCH-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*32-1:0] req_wdata;
  logic [NCH*4-1:0]  req_be;
  logic [31:0]       rsp_rdata;
  logic [21:0]       ctl_addr;
  logic              ctl_write_en, ctl_read_en, ctl_write_high_byte, ctl_write_low_byte;
  logic [15:0]       ctl_data_in, ctl_data_out;
  logic              ctl_busy, ctl_read_avail;

  rv32i_mem_bridge #(.NUM_CH(NCH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ctl_addr(ctl_addr), .ctl_write_en(ctl_write_en), .ctl_read_en(ctl_read_en),
    .ctl_data_in(ctl_data_in), .ctl_write_high_byte(ctl_write_high_byte),
    .ctl_write_low_byte(ctl_write_low_byte), .ctl_busy(ctl_busy),
    .ctl_read_avail(ctl_read_avail), .ctl_data_out(ctl_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: busy from the cycle after a strobe for lat cycles, read data on the last.
  int          lat;
  int          m_cnt;
  logic        m_pend, m_busy, m_avail, force_busy;
  logic [15:0] m_dout;
  logic [15:0] rd_q[$];
  assign ctl_busy       = m_busy | force_busy;
  assign ctl_read_avail = m_avail;
  assign ctl_data_out   = m_dout;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_avail <= 1'b0; m_dout <= '0; m_cnt <= 0; m_pend <= 1'b0;
    end else begin
      m_avail <= 1'b0;
      if (ctl_write_en || ctl_read_en) begin
        m_busy <= 1'b1; m_cnt <= lat; m_pend <= ctl_read_en;
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        m_cnt  <= 0;
        m_busy <= 1'b0;
        if (m_pend) begin
          m_avail <= 1'b1;
          m_dout  <= (rd_q.size() > 0) ? rd_q.pop_front() : 16'hDEAD;
          m_pend  <= 1'b0;
        end
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [21:0] addr;
    logic [15:0] data;
    logic        hb;
    logic        lb;
  } cmd_t;

  cmd_t        cmd_q[$];
  int          rsp_cnt[NCH];
  int          both_err, multi_rdy;
  logic [31:0] last_rdata;

  initial begin
    rsp_cnt[0] = 0; rsp_cnt[1] = 0; both_err = 0; multi_rdy = 0; last_rdata = '0;
  end

  always @(negedge clk) begin
    if (ctl_write_en || ctl_read_en)
      cmd_q.push_back({ctl_write_en, ctl_addr, ctl_data_in, ctl_write_high_byte, ctl_write_low_byte});
    if (ctl_write_en && ctl_read_en) both_err <= both_err + 1;
    if ($countones(req_ready) > 1) multi_rdy <= multi_rdy + 1;
    for (int c = 0; c < NCH; c++)
      if (rsp_valid[c]) rsp_cnt[c] <= rsp_cnt[c] + 1;
    if (|rsp_valid) last_rdata <= rsp_rdata;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [22:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    req_we[ch]             = we;
    req_addr[ch*AW +: AW]  = addr;
    req_wdata[ch*32 +: 32] = wdata;
    req_be[ch*4 +: 4]      = be;
  endtask

  task automatic send_req(input int ch, input logic we, input logic [22:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    bit got = 0;
    @(negedge clk);
    set_ch(ch, we, addr, wdata, be);
    req_valid[ch] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[ch]) begin got = 1; break; end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid[ch] = 1'b0;
  endtask

  task automatic wait_rsp(input int ch);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid[ch]) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int b, r0, r1, n;
  int g[4];

  initial begin
    lat = 2; force_busy = 1'b0;
    reset_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_strobes", {30'd0, ctl_write_en, ctl_read_en}, 32'd0);
    check("rst_ctl_addr", 32'(ctl_addr), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-word write: two beats, low first
    b = cmd_q.size(); r0 = rsp_cnt[0];
    send_req(0, 1'b1, 23'h10, 32'hA1B2C3D4, 4'hF);
    wait_rsp(0);
    check("w_ncmd", 32'(cmd_q.size() - b), 32'd2);
    check("w_lo_addr", 32'(cmd_q[b].addr), 32'd8);
    check("w_lo_data", 32'(cmd_q[b].data), 32'hC3D4);
    check("w_lo_we_hb_lb", {29'd0, cmd_q[b].we, cmd_q[b].hb, cmd_q[b].lb}, 32'd7);
    check("w_hi_addr", 32'(cmd_q[b+1].addr), 32'd9);
    check("w_hi_data", 32'(cmd_q[b+1].data), 32'hA1B2);
    check("w_hi_we_hb_lb", {29'd0, cmd_q[b+1].we, cmd_q[b+1].hb, cmd_q[b+1].lb}, 32'd7);
    check("w_rsp_cnt", 32'(rsp_cnt[0] - r0), 32'd1);
    check("w_rsp_rdata", last_rdata, 32'd0);

    // Single-byte write, low beat skipped
    b = cmd_q.size(); r1 = rsp_cnt[1];
    send_req(1, 1'b1, 23'h20, 32'h00EE0000, 4'h4);
    wait_rsp(1);
    check("be4_ncmd", 32'(cmd_q.size() - b), 32'd1);
    check("be4_addr", 32'(cmd_q[b].addr), 32'h11);
    check("be4_data", 32'(cmd_q[b].data), 32'h00EE);
    check("be4_hb_lb", {30'd0, cmd_q[b].hb, cmd_q[b].lb}, 32'd1);
    check("be4_rsp_cnt", 32'(rsp_cnt[1] - r1), 32'd1);

    // Full read
    b = cmd_q.size(); r0 = rsp_cnt[0];
    rd_q.push_back(16'hC3D4); rd_q.push_back(16'hA1B2);
    send_req(0, 1'b0, 23'h10, 32'h0, 4'hF);
    wait_rsp(0);
    check("rd_ncmd", 32'(cmd_q.size() - b), 32'd2);
    check("rd_addrs", {cmd_q[b].we, 9'd0, cmd_q[b].addr}, 32'd8);
    check("rd_addr_hi", {cmd_q[b+1].we, 9'd0, cmd_q[b+1].addr}, 32'd9);
    check("rd_rdata", last_rdata, 32'hA1B2C3D4);
    check("rd_rsp_cnt", 32'(rsp_cnt[0] - r0), 32'd1);

    // Read with be=1 and unaligned address still fetches both halfwords of word 4
    b = cmd_q.size();
    rd_q.push_back(16'h1234); rd_q.push_back(16'h5678);
    send_req(0, 1'b0, 23'h13, 32'h0, 4'h1);
    wait_rsp(0);
    check("rdbe_ncmd", 32'(cmd_q.size() - b), 32'd2);
    check("rdbe_addr_lo", 32'(cmd_q[b].addr), 32'd8);
    check("rdbe_rdata", last_rdata, 32'h56781234);

    // Write with no enables: no command, still a response
    b = cmd_q.size(); r0 = rsp_cnt[0];
    send_req(0, 1'b1, 23'h30, 32'hFFFFFFFF, 4'h0);
    wait_rsp(0);
    check("be0_ncmd", 32'(cmd_q.size() - b), 32'd0);
    check("be0_rsp_cnt", 32'(rsp_cnt[0] - r0), 32'd1);

    // Controller busy while in ISSUE_LO
    b = cmd_q.size();
    force_busy = 1'b1;
    send_req(0, 1'b1, 23'h4, 32'h0000BEEF, 4'h3);
    repeat (5) @(negedge clk);
    check("busy_no_strobe", 32'(cmd_q.size() - b), 32'd0);
    force_busy = 1'b0;
    wait_rsp(0);
    check("busy_one_strobe", 32'(cmd_q.size() - b), 32'd1);
    check("busy_addr_data", {2'd0, cmd_q[b].addr[13:0], cmd_q[b].data}, 32'h0002BEEF);

    // Reset while waiting on the high read beat
    lat = 4; r0 = rsp_cnt[0];
    rd_q.push_back(16'h1111); rd_q.push_back(16'h2222);
    send_req(0, 1'b0, 23'h40, 32'h0, 4'hF);
    n = 0;
    while (!(ctl_read_en && ctl_addr == 22'h21) && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) check("hi_strobe_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_strobes", {30'd0, ctl_write_en, ctl_read_en}, 32'd0);
    check("mid_rst_ctl_addr", 32'(ctl_addr), 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    rd_q.delete();
    lat = 2;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);
    rd_q.push_back(16'h3333); rd_q.push_back(16'h4444);
    send_req(1, 1'b0, 23'h40, 32'h0, 4'hF);
    wait_rsp(1);
    check("post_rst_rdata", last_rdata, 32'h44443333);

    // Both channels requesting continuously
    @(negedge clk);
    set_ch(0, 1'b1, 23'h100, 32'h01010101, 4'hF);
    set_ch(1, 1'b1, 23'h200, 32'h02020202, 4'hF);
    req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 400 && n < 4; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g[n] = req_ready[1] ? 1 : 0;
        n++;
      end
    end
    @(negedge clk);
    req_valid = 2'b00;
    check("arb_ngrants", 32'(n), 32'd4);
    if (n == 4) wait_rsp(g[3]);
`ifdef MEM_BRIDGE_RR_EN
    check("arb_g0", 32'(g[0]), 32'd0);
    check("arb_g1", 32'(g[1]), 32'd1);
    check("arb_g2", 32'(g[2]), 32'd0);
    check("arb_g3", 32'(g[3]), 32'd1);
`else
    check("arb_g0", 32'(g[0]), 32'd0);
    check("arb_g1", 32'(g[1]), 32'd0);
    check("arb_g2", 32'(g[2]), 32'd0);
    check("arb_g3", 32'(g[3]), 32'd0);
`endif

    check("never_both_strobes", 32'(both_err), 32'd0);
    check("ready_onehot", 32'(multi_rdy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/rv32i_mem_bridge.md
RV32I_MEM_BRIDGE -- requirements
Module: rv32i_mem_bridge

Interface
REQ-001 Parameter NUM_CH, default 2, number of requester channels (legal 1..4).
REQ-002 Parameter ADDR_W, default 23, requester byte-address width (legal 3..23).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_CH  per-channel request valid, held until accepted.
REQ-006 req_ready  output  NUM_CH  per-channel accept strobe, at most one bit high per cycle.
REQ-007 req_we  input  NUM_CH  per-channel write (1) / read (0).
REQ-008 req_addr  input  NUM_CH*ADDR_W  per-channel byte address; channel c occupies slice c.
REQ-009 req_wdata  input  NUM_CH*32  per-channel write data.
REQ-010 req_be  input  NUM_CH*4  per-channel byte enables; bit 0 = byte 0.
REQ-011 rsp_valid  output  NUM_CH  one-cycle completion pulse for the owning channel.
REQ-012 rsp_rdata  output  32  read data, valid only while any rsp_valid bit is high.
REQ-013 ctl_addr  output  22  PSRAM controller 16-bit-word address.
REQ-014 ctl_write_en / ctl_read_en  output  1 each  one-cycle command strobes.
REQ-015 ctl_data_in  output  16  write halfword.
REQ-016 ctl_write_high_byte / ctl_write_low_byte  output  1 each  halfword byte strobes.
REQ-017 ctl_busy  input  1  controller busy; asserts the cycle after a command strobe and holds until the command completes.
REQ-018 ctl_read_avail  input  1  one-cycle pulse; ctl_data_out is valid in that cycle.
REQ-019 ctl_data_out  input  16  read halfword.

Function
REQ-020 FSM states: IDLE, ARB, ISSUE_LO, WAIT_LO, ISSUE_HI, WAIT_HI, RESP.
REQ-021 IDLE -> ARB when any req_valid is high; ARB selects a channel, pulses its req_ready for exactly one cycle, latches we/addr/wdata/be, and goes to ISSUE_LO.
REQ-022 Address split: word index W = addr[ADDR_W-1:2]; low beat ctl_addr = 2W, high beat ctl_addr = 2W+1, zero-extended to 22 bits; addr[1:0] is ignored.
REQ-023 ISSUE_x strobes the command only in a cycle with ctl_busy=0, then enters WAIT_x; otherwise it stays in ISSUE_x with strobes low.
REQ-024 Low beat uses data[15:0] and be[1:0]; high beat uses data[31:16] and be[3:2]; high_byte = be odd bit, low_byte = be even bit.
REQ-025 Write beat whose two enables are both 0 is skipped with no strobe; a write with be=0 issues no command and goes straight to RESP.
REQ-026 WAIT_x for a write completes in the first cycle after entry with ctl_busy=0.
REQ-027 WAIT_x for a read completes on ctl_read_avail; the data is captured into the corresponding half of the read buffer.
REQ-028 Reads always issue both beats, regardless of be.
REQ-029 RESP pulses rsp_valid for the latched channel for one cycle, with rsp_rdata = {hi,lo} (writes: rsp_rdata = 0), then returns to IDLE.
REQ-030 Minimum latency: accept to rsp_valid is 1 + 2x(issue + controller latency) + 1 cycles; no overlap between transactions.
REQ-031 req_valid on the channel being serviced is ignored until RESP has completed.
REQ-032 A ctl_read_avail pulse outside WAIT_x in a read is ignored.
REQ-033 ctl_write_en and ctl_read_en are never high in the same cycle.

Reset
REQ-034 Asynchronous assertion: FSM -> IDLE, all outputs 0, read buffer 0, round-robin pointer 0.
REQ-035 Reset mid-transaction aborts it with no rsp_valid; the requester reissues.
REQ-036 After deassertion, the first accept occurs no earlier than the second rising edge.

Configuration
REQ-037 Macro MEM_BRIDGE_RR_EN defined: round-robin arbitration; the search starts at the channel after the last granted one, and the pointer updates only on a grant.
REQ-038 Macro MEM_BRIDGE_RR_EN undefined: fixed priority, lowest channel index wins; the pointer logic is absent.

Verification
REQ-039 Ch0 write addr 0x10, data 0xA1B2C3D4, be=0xF -> two writes: ctl_addr 8 data 0xC3D4, then ctl_addr 9 data 0xA1B2; both byte strobes 1; one rsp_valid[0].
REQ-040 Ch1 write be=0x4, data 0x00EE0000, addr 0x20 -> single command ctl_addr 0x11, data 0x00EE, high_byte 0, low_byte 1; low beat skipped.
REQ-041 Ch0 read addr 0x10, controller returns 0xC3D4 then 0xA1B2 -> rsp_rdata 0xA1B2C3D4 with rsp_valid[0] for exactly one cycle.
REQ-042 Ch0 and ch1 valid continuously for 4 transactions -> with MEM_BRIDGE_RR_EN the grants are 0,1,0,1; without it the grants are 0,0,0,0.
REQ-043 ctl_busy held high 5 cycles in ISSUE_LO -> no strobe until busy=0, then exactly one strobe.
REQ-044 reset_n low while in WAIT_HI -> outputs 0 in the same cycle, no rsp_valid, next request serviced normally.
